// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin scheduler sharing one 8N1 serial transmit line
// between up to eight byte requesters. Frames are start bit 0, eight data bits
// LSB first, stop bit 1, optionally followed by IDLE_GAP line-high cycles.
// One byte is accepted per grant; every output is registered.

module serial_tx_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IDLE_GAP = 0,
  localparam int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [PW-1:0]        owner,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // Wrap point of the rotating pointer; not a power-of-two modulo.
  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);
  localparam logic [PW:0]   NUM_REQ_W = (PW + 1)'(NUM_REQ);
  // GAP counts down from IDLE_GAP-1 to 0; the zero cycle is the decision point.
  localparam logic [3:0]    GAP_LOAD  = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  logic [2:0]         state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;

  logic               decide;
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [PW:0]        cand_sum;
  logic [PW-1:0]      cand;
  logic [7:0]         req_byte [NUM_REQ];

  // Split the flat data bus into one byte per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = data[8*gi +: 8];
  end

  // Cyclic search for the first active request starting at the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (PW + 1)'(k);
      if (cand_sum >= NUM_REQ_W) begin
        cand_sum = cand_sum - NUM_REQ_W;
      end
      cand = cand_sum[PW-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Frame sequencer and arbitration at decision points.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = '0;
    decide    = 1'b0;

    case (state_q)
      S_IDLE: begin
        decide = 1'b1;
      end
      S_START: begin
        state_d   = S_DATA;
        bit_cnt_d = 3'd0;
      end
      S_DATA: begin
        shift_d   = {1'b0, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (IDLE_GAP == 0) begin
          decide = 1'b1;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          decide = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The byte is captured here so the requester may change it right after.
    if (decide) begin
      if (win_found) begin
        state_d = S_START;
        shift_d = req_byte[win_idx];
        owner_d = win_idx;
        grant_d = {{(NUM_REQ - 1){1'b0}}, 1'b1} << win_idx;
        ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Line level and busy derived from the upcoming state so they can be registered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset truncates any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      gap_cnt_q <= 4'd0;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: a 4-requester no-gap instance (a) with a frame
// decoding scoreboard, and a 3-requester IDLE_GAP=2 instance (b).

module tb_serial_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_a;
  logic [31:0] data_a;
  logic [3:0]  grant_a;
  logic [1:0]  owner_a;
  logic        tx_a, busy_a;
  logic [2:0]  req_b;
  logic [23:0] data_b;
  logic [2:0]  grant_b;
  logic [1:0]  owner_b;
  logic        tx_b, busy_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         owner;
    logic [7:0] byt;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          win;
  } vec_t;
  vec_t vecs[7];

  int          cyc, bl, n, own;
  logic [7:0]  g;
  logic [7:0]  b;
  int          a5_seq[10];

  logic [7:0]  mbyte;
  int          mcnt = 0;
  int          mown = 0;

  serial_tx_arbiter #(.NUM_REQ(4), .IDLE_GAP(0)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .data(data_a),
    .grant(grant_a), .owner(owner_a), .tx(tx_a), .busy(busy_a)
  );

  serial_tx_arbiter #(.NUM_REQ(3), .IDLE_GAP(2)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .data(data_b),
    .grant(grant_b), .owner(owner_b), .tx(tx_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame decoder for instance a: pops the expected byte/owner at each stop bit.
  always @(negedge clk) begin
    if (reset) begin
      mcnt <= 0;
      sb_q.delete();
    end else if (mcnt == 0) begin
      if (tx_a === 1'b0) begin
        mcnt <= 1;
        mown <= int'(owner_a);
      end
    end else if (mcnt <= 8) begin
      mbyte <= {tx_a, mbyte[7:1]};
      mcnt  <= mcnt + 1;
    end else begin
      chk("stop_bit_a", tx_a, 1);
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_frame", sb_q.size(), 1);
      end else begin
        chk("sb_byte_a", mbyte, sb_q[0].byt);
        chk("sb_owner_a", mown, sb_q[0].owner);
        void'(sb_q.pop_front());
      end
      mcnt <= 0;
    end
  end

  // Line invariants on both instances.
  always @(negedge clk) begin
    if (!reset) begin
      chk("inv_onehot_a", $countones(grant_a) <= 1, 1);
      chk("inv_grant_start_a", (grant_a == 0) || (!tx_a && busy_a), 1);
      chk("inv_idle_high_a", busy_a || tx_a, 1);
      chk("inv_onehot_b", $countones(grant_b) <= 1, 1);
      chk("inv_grant_start_b", (grant_b == 0) || (!tx_b && busy_b), 1);
      chk("inv_idle_high_b", busy_b || tx_b, 1);
    end
  end

  task automatic wait_grant(input bit sel, output int c, output int lows,
                            output logic [7:0] gv, output int o);
    c = 0; lows = 0; gv = '0; o = 0;
    while (c < 40 && gv == 0) begin
      @(negedge clk);
      c++;
      gv = sel ? {5'b0, grant_b} : {4'b0, grant_a};
      if (gv == 0 && !(sel ? busy_b : busy_a)) lows++;
    end
    o = sel ? int'(owner_b) : int'(owner_a);
  endtask

  task automatic expect_grant(input int idx, input logic [7:0] byt, output int c,
                              output int lows);
    logic [7:0] gv;
    int o;
    wait_grant(1'b0, c, lows, gv, o);
    chk("grant_a", gv, 32'(1) << idx);
    chk("owner_a", o, idx);
    sb_q.push_back('{owner: idx, byt: byt});
  endtask

  task automatic wait_idle(input bit sel, output int cnt);
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt++;
      if (!(sel ? busy_b : busy_a)) break;
      if (cnt >= 40) break;
    end
    chk(sel ? "idle_timeout_b" : "idle_timeout_a", sel ? busy_b : busy_a, 0);
  endtask

  // Leaves the caller just after a negedge with reset released.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{req: 4'b0001, data: 32'h1F2E3D4C, win: 0};
    vecs[1] = '{req: 4'b1111, data: 32'h89ABCDEF, win: 1};
    vecs[2] = '{req: 4'b1001, data: 32'h80000001, win: 3};
    vecs[3] = '{req: 4'b1001, data: 32'h7F0000FE, win: 0};
    vecs[4] = '{req: 4'b0100, data: 32'h00550000, win: 2};
    vecs[5] = '{req: 4'b0011, data: 32'h0000C3E1, win: 0};
    vecs[6] = '{req: 4'b1000, data: 32'hB6000000, win: 3};
    a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    reset = 1'b1; req_a = '0; data_a = '0; req_b = '0; data_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_grant_a", grant_a, 0);
    chk("rst_owner_a", owner_a, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_busy_b", busy_b, 0);
    #1 reset = 1'b0;

    // Single byte 0xA5 with exact line pattern.
    req_a = 4'b0001; data_a = 32'h000000A5;
    expect_grant(0, 8'hA5, cyc, bl);
    chk("latency_a5", cyc, 1);
    chk("tx_a5_0", tx_a, a5_seq[0]);
    #1 req_a = '0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chk("tx_a5", tx_a, a5_seq[i]);
      chk("busy_a5", busy_a, 1);
      chk("grant_low_a5", grant_a, 0);
    end
    repeat (2) begin
      @(negedge clk);
      chk("tx_after_a5", tx_a, 1);
      chk("busy_after_a5", busy_a, 0);
    end

    // Table of isolated requests with pointer carried between vectors.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      req_a  = vecs[v].req;
      data_a = vecs[v].data;
      expect_grant(vecs[v].win, vecs[v].data[8*vecs[v].win +: 8], cyc, bl);
      chk("latency_vec", cyc, 1);
      #1 req_a = '0;
      wait_idle(1'b0, n);
      #1;
    end

    // All requesters held: 0,1,2,3,0 at 10-cycle spacing, busy never drops.
    do_reset();
    req_a = 4'b1111; data_a = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      b = data_a[8*(k%4) +: 8];
      expect_grant(k % 4, b, cyc, bl);
      if (k > 0) begin
        chk("spacing_all", cyc, 10);
        chk("busy_gap_all", bl, 0);
      end
    end
    #1 req_a = '0;
    wait_idle(1'b0, n);
    chk("drain_all", n, 10);
    #1;

    // Fairness: req0 held, req2 joins mid-frame.
    do_reset();
    req_a = 4'b0001; data_a = 32'h00C200C0;
    expect_grant(0, 8'hC0, cyc, bl);
    repeat (4) @(negedge clk);
    #1 req_a = 4'b0101;
    expect_grant(2, 8'hC2, cyc, bl);
    chk("fair_spacing1", cyc, 6);
    expect_grant(0, 8'hC0, cyc, bl);
    chk("fair_spacing2", cyc, 10);
    expect_grant(2, 8'hC2, cyc, bl);
    chk("fair_spacing3", cyc, 10);
    #1 req_a = '0;
    wait_idle(1'b0, n);
    #1;

    // Data stability: byte changes after grant, frame keeps 0x3C.
    do_reset();
    req_a = 4'b0010; data_a = 32'h00003C00;
    expect_grant(1, 8'h3C, cyc, bl);
    #1 req_a = '0;
    b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tx_stable", tx_a, b[i]);
      if (i == 0) #1 data_a = 32'h0000FF00;
    end
    wait_idle(1'b0, n);
    #1;

    // Reset during the fourth data bit, then pointer must be back at 0.
    do_reset();
    req_a = 4'b0001; data_a = 32'h0000005A;
    expect_grant(0, 8'h5A, cyc, bl);
    #1 req_a = '0;
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx_a, 1);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_grant", grant_a, 0);
    #1 reset = 1'b0;
    req_a = 4'b0101; data_a = 32'h00220011;
    expect_grant(0, 8'h11, cyc, bl);
    chk("midrst_latency", cyc, 1);
    #1 req_a = '0;
    wait_idle(1'b0, n);
    #1 req_a = 4'b0100;
    expect_grant(2, 8'h22, cyc, bl);
    #1 req_a = '0;
    wait_idle(1'b0, n);
    #1;

    // Gap instance: two requesters held, 2 idle cycles after each stop bit.
    do_reset();
    req_b = 3'b101; data_b = 24'hB200B0;
    wait_grant(1'b1, cyc, bl, g, own);
    chk("gap_grant0", g, 1);
    chk("gap_latency", cyc, 1);
    b = 8'hB0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        chk("gap_data", tx_b, b[k-1]);
      end else if (k < 12) begin
        chk("gap_high", tx_b, 1);
        chk("gap_busy", busy_b, 1);
        chk("gap_nogrant", grant_b, 0);
      end else begin
        chk("gap_start", tx_b, 0);
        chk("gap_grant2", grant_b, 3'b100);
        chk("gap_owner2", owner_b, 2);
      end
    end
    wait_grant(1'b1, cyc, bl, g, own);
    chk("gap_grant3", g, 1);
    chk("gap_owner3", own, 0);
    chk("gap_spacing", cyc, 12);
    chk("gap_busy_cont", bl, 0);
    #1 req_b = '0;
    wait_idle(1'b1, n);
    chk("gap_drain", n, 12);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
